// File: rtl/bellek_hakem_pkg.sv
// bellek_hakem shared definitions.
// FSM states and port-owner encodings.
package bellek_hakem_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2
  } durum_t;

  typedef enum logic {
    GETIR = 1'b0,
    BIB   = 1'b1
  } sahip_t;

endpackage

// File: rtl/bellek_hakem.sv
// Shares one memory port between fetch and the bib load/store path.
// bib has priority; an aging counter bounds fetch starvation.
module bellek_hakem
  import bellek_hakem_pkg::*;
#(
  parameter int ADR_BIT      = 32,
  parameter int ACLIK_SINIRI = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               gtr_istek_i,
  input  logic [ADR_BIT-1:0] gtr_adr_i,
  input  logic               gtr_iptal_i,
  output logic [31:0]        gtr_veri_o,
  output logic               gtr_gecerli_o,
  input  logic               bib_sec_i,
  input  logic [ADR_BIT-1:0] bib_adr_i,
  input  logic [31:0]        bib_veri_i,
  input  logic [3:0]         bib_veri_maske_i,
  output logic [31:0]        bib_veri_o,
  output logic               bib_durdur_o,
  output logic               mem_istek_o,
  output logic [ADR_BIT-1:0] mem_adr_o,
  output logic [31:0]        mem_veri_o,
  output logic [3:0]         mem_maske_o,
  output logic               mem_yaz_o,
  input  logic               mem_hazir_i,
  input  logic [31:0]        mem_veri_i,
  input  logic               mem_gecerli_i
);

  localparam int SW = $clog2(ACLIK_SINIRI + 1);
  localparam logic [SW-1:0] SINIR = SW'(ACLIK_SINIRI);

  durum_t             durum_q, durum_d;
  sahip_t             sahip_q, sahip_d;
  logic [SW-1:0]      ac_q, ac_d;
  logic               iptal_q, iptal_d;
  logic [ADR_BIT-1:0] adr_q, adr_d;
  logic [31:0]        veri_q, veri_d;
  logic [3:0]         maske_q, maske_d;
  logic               yaz_q, yaz_d;
  logic               istek_q;

  logic yanit_var;
  logic gtr_sahip;

  assign yanit_var = mem_gecerli_i && (durum_q == YANIT);
  assign gtr_sahip = (sahip_q == GETIR);

  always_comb begin
    durum_d = durum_q;
    sahip_d = sahip_q;
    ac_d    = ac_q;
    iptal_d = iptal_q;
    adr_d   = adr_q;
    veri_d  = veri_q;
    maske_d = maske_q;
    yaz_d   = yaz_q;
    unique case (durum_q)
      BOSTA: begin
        iptal_d = 1'b0;
        if (bib_sec_i && !(gtr_istek_i && ac_q == SINIR)) begin
          durum_d = ISTEK;
          sahip_d = BIB;
          adr_d   = bib_adr_i;
          veri_d  = bib_veri_i;
          maske_d = bib_veri_maske_i;
          yaz_d   = |bib_veri_maske_i;
          // ac_q < SINIR here whenever fetch waits
          ac_d    = gtr_istek_i ? ac_q + 1'b1 : '0;
        end else if (gtr_istek_i && !gtr_iptal_i) begin
          durum_d = ISTEK;
          sahip_d = GETIR;
          adr_d   = gtr_adr_i;
          veri_d  = '0;
          maske_d = '0;
          yaz_d   = 1'b0;
          ac_d    = '0;
        end else if (!gtr_istek_i) begin
          ac_d = '0;
        end
      end
      ISTEK: begin
        if (gtr_sahip && gtr_iptal_i)
          iptal_d = 1'b1;
        if (mem_hazir_i)
          durum_d = YANIT;
      end
      YANIT: begin
        if (gtr_sahip && gtr_iptal_i)
          iptal_d = 1'b1;
        if (mem_gecerli_i) begin
          durum_d = BOSTA;
          iptal_d = 1'b0;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q <= BOSTA;
      sahip_q <= GETIR;
      ac_q    <= '0;
      iptal_q <= 1'b0;
      adr_q   <= '0;
      veri_q  <= '0;
      maske_q <= '0;
      yaz_q   <= 1'b0;
      istek_q <= 1'b0;
    end else begin
      durum_q <= durum_d;
      sahip_q <= sahip_d;
      ac_q    <= ac_d;
      iptal_q <= iptal_d;
      adr_q   <= adr_d;
      veri_q  <= veri_d;
      maske_q <= maske_d;
      yaz_q   <= yaz_d;
      istek_q <= (durum_d == ISTEK);
    end
  end

  assign mem_istek_o = istek_q;
  assign mem_adr_o   = adr_q;
  assign mem_veri_o  = veri_q;
  assign mem_maske_o = maske_q;
  assign mem_yaz_o   = yaz_q;

  assign gtr_veri_o    = mem_veri_i;
  assign bib_veri_o    = mem_veri_i;
  assign gtr_gecerli_o = yanit_var && gtr_sahip
                      && !iptal_q && !gtr_iptal_i;
  assign bib_durdur_o  = bib_sec_i
                      && !(yanit_var && sahip_q == BIB);

endmodule

// File: tb/tb_bellek_hakem.sv
// Directed bench for bellek_hakem.
// Hand-computed expectations, one check task.
module tb_bellek_hakem;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        gtr_istek_i;
  logic [31:0] gtr_adr_i;
  logic        gtr_iptal_i;
  logic [31:0] gtr_veri_o;
  logic        gtr_gecerli_o;
  logic        bib_sec_i;
  logic [31:0] bib_adr_i;
  logic [31:0] bib_veri_i;
  logic [3:0]  bib_veri_maske_i;
  logic [31:0] bib_veri_o;
  logic        bib_durdur_o;
  logic        mem_istek_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_veri_o;
  logic [3:0]  mem_maske_o;
  logic        mem_yaz_o;
  logic        mem_hazir_i;
  logic [31:0] mem_veri_i;
  logic        mem_gecerli_i;

  int n_test = 0;
  int n_hata = 0;

  always #5 clk_i = ~clk_i;

  bellek_hakem #(.ADR_BIT(32), .ACLIK_SINIRI(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .gtr_istek_i      (gtr_istek_i),
    .gtr_adr_i        (gtr_adr_i),
    .gtr_iptal_i      (gtr_iptal_i),
    .gtr_veri_o       (gtr_veri_o),
    .gtr_gecerli_o    (gtr_gecerli_o),
    .bib_sec_i        (bib_sec_i),
    .bib_adr_i        (bib_adr_i),
    .bib_veri_i       (bib_veri_i),
    .bib_veri_maske_i (bib_veri_maske_i),
    .bib_veri_o       (bib_veri_o),
    .bib_durdur_o     (bib_durdur_o),
    .mem_istek_o      (mem_istek_o),
    .mem_adr_o        (mem_adr_o),
    .mem_veri_o       (mem_veri_o),
    .mem_maske_o      (mem_maske_o),
    .mem_yaz_o        (mem_yaz_o),
    .mem_hazir_i      (mem_hazir_i),
    .mem_veri_i       (mem_veri_i),
    .mem_gecerli_i    (mem_gecerli_i)
  );

  task automatic kontrol(input string etiket,
                         input logic [63:0] gozlenen,
                         input logic [63:0] beklenen);
    n_test++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got %0h expected %0h",
               etiket, gozlenen, beklenen);
    end
  endtask

  task automatic adim();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bekle_istek(input string etiket);
    int k;
    k = 0;
    while (!mem_istek_o && k < 6) begin
      adim();
      #1;
      k++;
    end
    if (!mem_istek_o)
      kontrol({etiket, "_timeout"}, 64'(mem_istek_o), 64'd1);
  endtask

  logic [31:0] sira [10];

  initial begin
    rst_i = 1'b0;
    gtr_istek_i = 0; gtr_adr_i = 0; gtr_iptal_i = 0;
    bib_sec_i = 0; bib_adr_i = 0; bib_veri_i = 0;
    bib_veri_maske_i = 0;
    mem_hazir_i = 0; mem_veri_i = 0; mem_gecerli_i = 0;
    repeat (3) adim();
    #1;
    kontrol("rst_istek", 64'(mem_istek_o), 64'd0);
    kontrol("rst_adr", 64'(mem_adr_o), 64'd0);
    kontrol("rst_yaz", 64'({mem_yaz_o, mem_maske_o}), 64'd0);
    kontrol("rst_gecerli", 64'(gtr_gecerli_o), 64'd0);
    rst_i = 1'b1;
    adim();

    // fetch only, minimum latency
    gtr_istek_i = 1; gtr_adr_i = 32'h100; mem_hazir_i = 1;
    #1 kontrol("f_c0_istek", 64'(mem_istek_o), 64'd0);
    adim();
    #1 kontrol("f_c1_istek", 64'(mem_istek_o), 64'd1);
    kontrol("f_c1_adr", 64'(mem_adr_o), 64'h100);
    kontrol("f_c1_yaz", 64'(mem_yaz_o), 64'd0);
    kontrol("f_c1_gec", 64'(gtr_gecerli_o), 64'd0);
    adim();
    mem_gecerli_i = 1; mem_veri_i = 32'hDEADBEEF;
    #1 kontrol("f_c2_gec", 64'(gtr_gecerli_o), 64'd1);
    kontrol("f_c2_veri", 64'(gtr_veri_o), 64'hDEADBEEF);
    kontrol("f_c2_istek", 64'(mem_istek_o), 64'd0);
    gtr_istek_i = 0;
    adim();
    mem_gecerli_i = 0;
    #1 kontrol("f_c3_gec", 64'(gtr_gecerli_o), 64'd0);
    adim();
    #1 kontrol("f_c4_istek", 64'(mem_istek_o), 64'd0);

    // store
    bib_sec_i = 1; bib_adr_i = 32'h2000;
    bib_veri_maske_i = 4'b0011; bib_veri_i = 32'h1234;
    #1 kontrol("s_c0_durdur", 64'(bib_durdur_o), 64'd1);
    adim();
    #1 kontrol("s_c1_yaz", 64'(mem_yaz_o), 64'd1);
    kontrol("s_c1_maske", 64'(mem_maske_o), 64'h3);
    kontrol("s_c1_veri", 64'(mem_veri_o), 64'h1234);
    kontrol("s_c1_adr", 64'(mem_adr_o), 64'h2000);
    kontrol("s_c1_durdur", 64'(bib_durdur_o), 64'd1);
    adim();
    #1 kontrol("s_c2_durdur", 64'(bib_durdur_o), 64'd1);
    mem_gecerli_i = 1;
    #1 kontrol("s_ack_durdur", 64'(bib_durdur_o), 64'd0);
    kontrol("s_ack_gtr", 64'(gtr_gecerli_o), 64'd0);
    bib_sec_i = 0; bib_veri_maske_i = 0;
    adim();
    mem_gecerli_i = 0;

    // backpressure
    gtr_istek_i = 1; gtr_adr_i = 32'h300; mem_hazir_i = 0;
    adim();
    for (int k = 0; k < 5; k++) begin
      #1 kontrol("bp_hold", 64'({mem_istek_o, mem_adr_o}),
                 {31'd0, 1'b1, 32'h300});
      adim();
    end
    mem_hazir_i = 1;
    #1 kontrol("bp_6th", 64'(mem_istek_o), 64'd1);
    adim();
    #1 kontrol("bp_acc", 64'(mem_istek_o), 64'd0);
    mem_gecerli_i = 1; mem_veri_i = 32'h0BAD0300;
    #1 kontrol("bp_gec", 64'(gtr_gecerli_o), 64'd1);
    gtr_istek_i = 0;
    adim();
    mem_gecerli_i = 0;

    // flush of an in-flight fetch
    gtr_istek_i = 1; gtr_adr_i = 32'h400;
    adim();
    adim();
    gtr_iptal_i = 1;
    adim();
    gtr_iptal_i = 0; gtr_istek_i = 0;
    mem_gecerli_i = 1; mem_veri_i = 32'h44444444;
    #1 kontrol("fl_discard", 64'(gtr_gecerli_o), 64'd0);
    adim();
    mem_gecerli_i = 0;
    gtr_istek_i = 1; gtr_adr_i = 32'h200;
    adim();
    #1 kontrol("fl_next_adr", 64'(mem_adr_o), 64'h200);
    adim();
    mem_gecerli_i = 1; mem_veri_i = 32'hCAFEF00D;
    #1 kontrol("fl_next_gec", 64'(gtr_gecerli_o), 64'd1);
    kontrol("fl_next_veri", 64'(gtr_veri_o), 64'hCAFEF00D);
    gtr_istek_i = 0;
    adim();
    mem_gecerli_i = 0;

    // flush in idle blocks the grant
    gtr_istek_i = 1; gtr_iptal_i = 1; gtr_adr_i = 32'h480;
    adim();
    #1 kontrol("fl_idle", 64'(mem_istek_o), 64'd0);
    gtr_istek_i = 0; gtr_iptal_i = 0;
    adim();

    // contention, zero-wait memory
    sira = '{32'h600, 32'h600, 32'h600, 32'h600, 32'h500,
             32'h600, 32'h600, 32'h600, 32'h600, 32'h500};
    mem_hazir_i = 1; mem_gecerli_i = 1; mem_veri_i = 32'h77;
    gtr_istek_i = 1; gtr_adr_i = 32'h500;
    bib_sec_i = 1; bib_adr_i = 32'h600; bib_veri_maske_i = 0;
    for (int i = 0; i < 10; i++) begin
      bekle_istek("ct_wait");
      kontrol($sformatf("ct_grant%0d", i), 64'(mem_adr_o),
              64'(sira[i]));
      adim();
    end
    gtr_istek_i = 0; bib_sec_i = 0;
    repeat (3) adim();
    mem_gecerli_i = 0;
    adim();

    // async reset in YANIT
    gtr_istek_i = 1; gtr_adr_i = 32'h700;
    adim();
    adim();
    #3 rst_i = 1'b0;
    #1 kontrol("ar_istek", 64'(mem_istek_o), 64'd0);
    kontrol("ar_adr", 64'(mem_adr_o), 64'd0);
    gtr_istek_i = 0;
    bib_sec_i = 1; mem_gecerli_i = 1;
    #1 kontrol("ar_gtr", 64'(gtr_gecerli_o), 64'd0);
    kontrol("ar_durdur", 64'(bib_durdur_o), 64'd1);
    adim();
    #1 kontrol("ar_gtr2", 64'(gtr_gecerli_o), 64'd0);
    bib_sec_i = 0; mem_gecerli_i = 0;
    rst_i = 1'b1;
    adim();

    $display("[TB] %0d tests run, %0d failed", n_test, n_hata);
    $finish;
  end

endmodule
